mul16_share_arbiter: RTL and testbench
======================================

MUL16_SHARE_ARBITER -- requirements
Module: mul16_share_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of the accepted-operation counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 req_signed0 / req_signed1  input  1 each  1 = signed operands, 0 = unsigned.
REQ-007 req_a0 / req_a1  input  16 each  multiplicand.
REQ-008 req_b0 / req_b1  input  16 each  multiplier.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  32  32-bit product.
REQ-013 op_count  output  CNT_W  number of accepted requests, saturating.

Function
REQ-014 The block SHALL contain exactly one instance of the shared 16x16 radix-4 Booth/Wallace multiplier and SHALL drive it only from stage-1 registers.
REQ-015 A request is accepted on a cycle where req_valid[i] && req_ready[i]; stage 1 (s1_valid, id, signed, a, b) loads on that edge.
REQ-016 Stage 2 (rsp_valid, rsp_id, rsp_data) SHALL load the product of stage 1 when s1_valid && (!rsp_valid || rsp_ready).
REQ-017 Latency SHALL be 2 cycles: accept at edge N gives rsp_valid=1 after edge N+1 when there is no backpressure.
REQ-018 Throughput SHALL be one result per cycle while rsp_ready=1.
REQ-019 The stage-1 accept condition SHALL be s1_free = !s1_valid || (!rsp_valid || rsp_ready); req_ready SHALL be 0 on both bits when s1_free=0.
REQ-020 Arbitration SHALL be round-robin through a 1-bit last-grant pointer (lg):
- both requesters valid: grant requester !lg;
- one requester valid: grant that requester.
REQ-021 lg SHALL update to the granted index only on an accepted request; no update on a stall or an idle cycle.
REQ-022 req_ready SHALL depend only on the registered state and req_valid, never on rsp_data.
REQ-023 While rsp_valid=1 && rsp_ready=0, rsp_valid, rsp_id and rsp_data SHALL stay stable, and stage 1 SHALL hold.
REQ-024 The simultaneous events "stage 2 drains", "stage 1 advances" and "new accept" in the same cycle SHALL all occur with no lost or duplicated result.
REQ-025 A stage-1 entry with s1_valid=0 SHALL never produce rsp_valid.
REQ-026 op_count SHALL increment by 1 per accept and SHALL saturate at all-ones.

Reset
REQ-027 On rst=1 at a clock edge, the following SHALL reset, discarding any in-flight operation:
- s1_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0;
- op_count=0;
- lg=1, so requester 0 wins first.
REQ-028 req_ready SHALL be 0 on every cycle in which rst=1.
REQ-029 The block SHALL accept a request on the first cycle after rst deasserts.

Configuration
REQ-030 Macro MUL16_ARB_FIXED_PRIO_EN:
- defined: requester 0 SHALL always win over requester 1, and lg SHALL be unused;
- undefined: the round-robin of REQ-020/021 SHALL apply.

Verification
REQ-031 Unsigned: req0 a=0xFFFF, b=0xFFFF, signed=0 -> rsp_data=0xFFFE0001, rsp_id=0, 2 cycles after the accept.
REQ-032 Signed: req1 a=0x8000, b=0x8000 -> 0x40000000; then a=0xFFFF, b=0x0002 -> 0xFFFFFFFE; both with rsp_id=1.
REQ-033 Both req_valid held high for 4 accepts after reset -> grants 0,1,0,1 (with the macro: 0,0,0,0), and op_count=4.
REQ-034 rsp_ready=0 for 5 cycles with 3 requests pending -> rsp fields stable, only 2 results buffered, req_ready=0; after release, results arrive in order on consecutive cycles.
REQ-035 rst asserted with both stages valid -> next cycle rsp_valid=0 and op_count=0; the first post-reset accept goes to requester 0.

Source files
------------

// File: rtl/mul16_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul16_share_arbiter
//
// Two requesters share a single 16x16 multiplier (radix-4 Booth partial
// products reduced by a Wallace carry-save tree). A round-robin arbiter picks
// one request per cycle into stage 1. The multiplier is fed only from the
// stage-1 registers, and stage 2 registers the product as the response.
// Result latency is 2 cycles. Throughput is one result per cycle while the
// consumer is ready.
//
// Configuration macro:
//   MUL16_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins and there is
//                                         no last-grant pointer.
//                            undefined -> round-robin on a 1-bit last-grant
//                                         pointer (the default build).
//
// Ports (mul16_share_arbiter):
//   clk          clock; every state change happens on its rising edge
//   rst          synchronous active-high reset
//   req_valid    [1:0] per-requester request valid
//   req_ready    [1:0] per-requester accept (at most one bit high)
//   req_signed0/1  1 = signed operands, 0 = unsigned
//   req_a0/1     [15:0] multiplicand
//   req_b0/1     [15:0] multiplier
//   rsp_valid    result available
//   rsp_ready    consumer takes the result
//   rsp_id       requester that owns the result
//   rsp_data     [31:0] product
//   op_count     [CNT_W-1:0] accepted requests, saturating at all-ones
// -----------------------------------------------------------------------------

// Combinational 16x16 multiplier. It handles signed and unsigned operands.
//   sgn   1 = both operands are two's complement
//   a, b  operands
//   p     low 32 bits of the product. This is the exact product in both modes.
module mul16_booth_wallace (
  input  logic        sgn,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] c;
  } csa_t;

  // One 3:2 compressor row. The carry vector is already shifted into place.
  function automatic csa_t csa(input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  // Each operand is extended by one sign or zero bit, which makes it a 17-bit
  // signed value. The whole datapath then works modulo 2^32, because only the
  // low 32 product bits are kept.
  logic [31:0] x_ext;
  logic [18:0] y_pad;      // multiplier with the implicit y[-1] = 0 at bit 0
  logic [2:0]  trip;
  logic [31:0] mag;
  logic        neg;
  logic [31:0] neg_row;
  logic [31:0] pp [10];

  // NOTE: give every variable written in always_comb a value before any
  // branch. If a path leaves a variable unassigned, synthesis infers a latch.
  always_comb begin
    x_ext   = {{16{sgn & a[15]}}, a};
    y_pad   = {{2{sgn & b[15]}}, b, 1'b0};
    trip    = '0;
    mag     = '0;
    neg     = 1'b0;
    neg_row = '0;
    for (int j = 0; j < 9; j++) begin
      trip = y_pad[2*j +: 3];
      unique case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = x_ext;
        3'b011, 3'b100:                 mag = x_ext << 1;
        default:                        mag = '0;
      endcase
      // A negative digit uses the inverted magnitude plus a hot one at bit 2j.
      // The hot ones for all digits are collected in a tenth row, so no
      // per-row adder is needed.
      neg = trip[2] & ~(trip[1] & trip[0]);
      pp[j] = (neg ? ~mag : mag) << (2 * j);
      neg_row[2*j] = neg;
    end
    pp[9] = neg_row;
  end

  // Wallace reduction of the 10 rows, in levels of 7, 5, 4, 3 and 2 rows.
  csa_t l1_0, l1_1, l1_2, l2_0, l2_1, l3, l4, l5;

  assign l1_0 = csa(pp[0], pp[1], pp[2]);
  assign l1_1 = csa(pp[3], pp[4], pp[5]);
  assign l1_2 = csa(pp[6], pp[7], pp[8]);

  assign l2_0 = csa(l1_0.s, l1_0.c, l1_1.s);
  assign l2_1 = csa(l1_1.c, l1_2.s, l1_2.c);

  assign l3 = csa(l2_0.s, l2_0.c, l2_1.s);
  assign l4 = csa(l3.s, l3.c, l2_1.c);
  assign l5 = csa(l4.s, l4.c, pp[9]);

  assign p = l5.s + l5.c;

endmodule

module mul16_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic             req_signed0,
  input  logic             req_signed1,
  input  logic [15:0]      req_a0,
  input  logic [15:0]      req_a1,
  input  logic [15:0]      req_b0,
  input  logic [15:0]      req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic [CNT_W-1:0] op_count
);

  // Stage 1: the accepted operation, which feeds the shared multiplier.
  logic        s1_valid;
  logic        s1_id;
  logic        s1_signed;
  logic [15:0] s1_a;
  logic [15:0] s1_b;

`ifndef MUL16_ARB_FIXED_PRIO_EN
  logic        lg;          // last granted requester
`endif

  logic        s1_free;     // stage 1 can take a new operation this cycle
  logic        s1_adv;      // stage 1 moves into stage 2 this cycle
  logic [1:0]  grant;
  logic        accept;
  logic        acc_id;
  logic [31:0] product;

  // Stage 1 is free if it is empty, or if its entry moves on at this edge.
  // An entry moves on when stage 2 is empty or is being drained.
  assign s1_free = !s1_valid || !rsp_valid || rsp_ready;
  assign s1_adv  = s1_valid && (!rsp_valid || rsp_ready);

  // The grant uses only registered state, req_valid and rst. It never uses
  // the product.
  always_comb begin
    grant = 2'b00;
    if (!rst && s1_free) begin
`ifdef MUL16_ARB_FIXED_PRIO_EN
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
`else
      if (req_valid == 2'b11) grant = lg ? 2'b01 : 2'b10;
      else                    grant = req_valid;
`endif
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign acc_id    = grant[1];

  // The only multiplier instance. Its inputs come only from stage-1 registers.
  mul16_booth_wallace u_mul (
    .sgn (s1_signed),
    .a   (s1_a),
    .b   (s1_b),
    .p   (product)
  );

  // Control state and response registers.
  // NOTE: sequential state is written only with non-blocking assignments
  // (<=). All registers then update together at the edge, and the order of
  // the statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      op_count  <= '0;
`ifndef MUL16_ARB_FIXED_PRIO_EN
      lg        <= 1'b1;    // requester 0 wins the first contested cycle
`endif
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;

      // Stage 2 loads from stage 1, or clears when its result is taken.
      // During a stall nothing here changes, so the response stays stable.
      if (s1_adv) begin
        rsp_valid <= 1'b1;
        rsp_id    <= s1_id;
        rsp_data  <= product;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (accept && (op_count != {CNT_W{1'b1}})) op_count <= op_count + 1'b1;

`ifndef MUL16_ARB_FIXED_PRIO_EN
      if (accept) lg <= acc_id;
`endif
    end
  end

  // Stage-1 payload.
  // NOTE: the payload registers are deliberately left out of reset.
  // s1_valid qualifies them, so their value after reset is never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_id     <= acc_id;
      s1_signed <= acc_id ? req_signed1 : req_signed0;
      s1_a      <= acc_id ? req_a1 : req_a0;
      s1_b      <= acc_id ? req_b1 : req_b0;
    end
  end

endmodule

// File: tb/tb_mul16_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul16_share_arbiter
//
// Self-checking bench for mul16_share_arbiter. It has three parts:
//   - a table of hand-computed products, applied one request at a time
//   - hand-written sequences for arbitration, backpressure and mid-flight reset
//   - randomized traffic checked against a transaction-level model
// The model keeps the accepted operations in a queue. Pipeline capacity is two
// entries. A result becomes visible one edge after its accept. Products are
// computed with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mul16_share_arbiter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic             req_signed0, req_signed1;
  logic [15:0]      req_a0, req_a1, req_b0, req_b1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_data;
  logic [CNT_W-1:0] op_count;

  mul16_share_arbiter #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_signed0 (req_signed0),
    .req_signed1 (req_signed1),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_b0      (req_b0),
    .req_b1      (req_b1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic        id;
    logic [31:0] data;
    int          edge_no;   // edge at which the request was accepted
  } exp_t;

  exp_t mq[$];
  int   edge_no;
  logic m_lg;
  int   m_count;

  // DUT values sampled at the most recent negedge
  logic        obs_rsp_valid, obs_rsp_id;
  logic [31:0] obs_rsp_data;
  logic [1:0]  obs_req_ready;
  logic [31:0] obs_op_count;

  function automatic logic [31:0] ref_mul(input logic sgn, input logic [15:0] a,
                                          input logic [15:0] b);
    longint pa, pb;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    return 32'(pa * pb);
  endfunction

  function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic lg,
                                           input bit free);
    if (!free || v == 2'b00) return 2'b00;
`ifdef MUL16_ARB_FIXED_PRIO_EN
    return v[0] ? 2'b01 : 2'b10;
`else
    if (v == 2'b11) return lg ? 2'b01 : 2'b10;
    return v;
`endif
  endfunction

  // Checks one cycle at the negedge and advances the model past the next
  // posedge. Returns #1 after that posedge, which is when inputs may change.
  task automatic observe_and_step();
    logic [1:0] g;
    bit         free;
    bit         exp_rv;
    @(negedge clk);
    obs_rsp_valid = rsp_valid;
    obs_rsp_id    = rsp_id;
    obs_rsp_data  = rsp_data;
    obs_req_ready = req_ready;
    obs_op_count  = 32'(op_count);
    free   = (mq.size() < 2) || rsp_ready;
    g      = ref_grant(req_valid, m_lg, free);
    exp_rv = (mq.size() > 0) && (mq[0].edge_no < edge_no);
    check("req_ready", 32'(req_ready), 32'(g));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_id", 32'(rsp_id), 32'(mq[0].id));
      check("rsp_data", rsp_data, mq[0].data);
    end
    check("op_count", 32'(op_count), 32'(m_count));
    if (exp_rv && rsp_ready) void'(mq.pop_front());
    if (g != 2'b00) begin
      exp_t e;
      e.id      = g[1];
      e.data    = g[1] ? ref_mul(req_signed1, req_a1, req_b1)
                       : ref_mul(req_signed0, req_a0, req_b0);
      e.edge_no = edge_no + 1;
      mq.push_back(e);
      m_lg = g[1];
      if (m_count < (1 << CNT_W) - 1) m_count++;
    end
    edge_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("req_ready_in_rst", 32'(req_ready), 32'd0);
      if (i > 0) begin
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    mq.delete();
    m_lg    = 1'b1;
    m_count = 0;
    edge_no = 0;
  endtask

  task automatic drive_req(input logic id, input logic sgn, input logic [15:0] a,
                           input logic [15:0] b);
    if (id) begin
      req_signed1 = sgn; req_a1 = a; req_b1 = b;
    end else begin
      req_signed0 = sgn; req_a0 = a; req_b0 = b;
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------- tables
  typedef struct {
    logic        id;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  logic [1:0]  arb_exp [4];
  logic [1:0]  arb_got [4];
  logic [15:0] bp_a [3];
  logic [15:0] bp_b [3];
  logic [31:0] bp_exp [3];

  initial begin
    int n_acc, n_rsp, n_arb;
    int rsp_cyc [3];
    bit have_snap;
    logic [31:0] snap_data;
    logic        snap_id;

    vecs[0] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 16'h5678, 32'h06260060};
    vecs[4] = '{1'b1, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h1234, 32'h00000000};
    vecs[7] = '{1'b0, 1'b1, 16'h0003, 16'hFFFD, 32'hFFFFFFF7};
    vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE};
    vecs[9] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 32'h40000000};

`ifdef MUL16_ARB_FIXED_PRIO_EN
    arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    bp_a   = '{16'h0003, 16'h0100, 16'hFFFF};
    bp_b   = '{16'h0005, 16'h0100, 16'h0001};
    bp_exp = '{32'h0000000F, 32'h00010000, 32'h0000FFFF};

    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_signed0 = 1'b0; req_signed1 = 1'b0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;

    do_reset(2);

    // Table vectors: one request at a time, checking the 2-cycle latency.
    foreach (vecs[i]) begin
      drive_req(vecs[i].id, vecs[i].sgn, vecs[i].a, vecs[i].b);
      req_valid = vecs[i].id ? 2'b10 : 2'b01;
      observe_and_step();                       // accept edge
      req_valid = 2'b00;
      observe_and_step();
      check("vec_latency_early", 32'(obs_rsp_valid), 32'd0);
      observe_and_step();
      check("vec_rsp_valid", 32'(obs_rsp_valid), 32'd1);
      check("vec_rsp_id", 32'(obs_rsp_id), 32'(vecs[i].id));
      check("vec_rsp_data", obs_rsp_data, vecs[i].exp);
    end

    // Both requesters stay valid from reset onwards: the first cycle after
    // reset accepts, and the grants alternate.
    req_valid = 2'b11;
    drive_req(1'b0, 1'b0, 16'h0011, 16'h0022);
    drive_req(1'b1, 1'b1, 16'hFFF0, 16'h0010);
    do_reset(2);
    n_arb = 0;
    for (int c = 0; c < 20 && n_arb < 4; c++) begin
      observe_and_step();
      if (obs_req_ready != 2'b00) begin
        arb_got[n_arb] = obs_req_ready;
        n_arb++;
      end
    end
    req_valid = 2'b00;
    check("arb_accepts", 32'(n_arb), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < n_arb) check("arb_grant", 32'(arb_got[i]), 32'(arb_exp[i]));
    observe_and_step();
    check("arb_op_count", obs_op_count, 32'd4);
    repeat (3) observe_and_step();

    // Backpressure: three pending requests and rsp_ready held low.
    do_reset(2);
    rsp_ready = 1'b0;
    n_acc = 0; have_snap = 0; snap_data = '0; snap_id = 1'b0;
    drive_req(1'b0, 1'b0, bp_a[0], bp_b[0]);
    req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      observe_and_step();
      if (obs_rsp_valid) begin
        if (!have_snap) begin
          snap_data = obs_rsp_data; snap_id = obs_rsp_id; have_snap = 1;
          check("bp_first_data", snap_data, bp_exp[0]);
        end else begin
          check("bp_hold_data", obs_rsp_data, snap_data);
          check("bp_hold_id", 32'(obs_rsp_id), 32'(snap_id));
        end
      end
      if (obs_req_ready[0]) begin
        n_acc++;
        if (n_acc < 3) drive_req(1'b0, 1'b0, bp_a[n_acc], bp_b[n_acc]);
        else           req_valid = 2'b00;
      end
    end
    check("bp_buffered", 32'(n_acc), 32'd2);
    check("bp_ready_low", 32'(obs_req_ready), 32'd0);
    rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 10 && n_rsp < 3; c++) begin
      observe_and_step();
      if (obs_rsp_valid) begin
        check("bp_order", obs_rsp_data, bp_exp[n_rsp]);
        rsp_cyc[n_rsp] = c;
        n_rsp++;
      end
      if (obs_req_ready[0]) begin
        n_acc++;
        req_valid = 2'b00;
      end
    end
    check("bp_results", 32'(n_rsp), 32'd3);
    if (n_rsp == 3) check("bp_consecutive", 32'(rsp_cyc[2] - rsp_cyc[0]), 32'd2);
    req_valid = 2'b00;
    repeat (2) observe_and_step();

    // Reset with both stages holding a valid operation.
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 16'h1357, 16'h2468);
    req_valid = 2'b01;
    repeat (2) observe_and_step();
    check("full_before_rst", 32'(mq.size()), 32'd2);
    req_valid = 2'b11;
    do_reset(2);
    rsp_ready = 1'b1;
    observe_and_step();
    check("post_rst_grant", 32'(obs_req_ready), 32'h1);
    req_valid = 2'b00;
    repeat (3) observe_and_step();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      req_valid   = 2'($urandom);
      rsp_ready   = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      req_signed0 = 1'($urandom); req_signed1 = 1'($urandom);
      req_a0 = rnd16(); req_b0 = rnd16();
      req_a1 = rnd16(); req_b1 = rnd16();
      observe_and_step();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (4) observe_and_step();
    check("drain_empty", 32'(mq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
